debug_record_arbiter: RTL and testbench
=======================================

Name: debug_record_arbiter

Overview:
- Shares one narrow debug output channel among SRC_NUM debug-record sources, e.g. per-stage debug register groups and the performance counter snapshot.
- Picks a source with round-robin arbitration and captures its record into a snapshot register.
- Streams the record out as REC_WORDS beats over a valid/ready handshake.
- Sits between the per-stage debug outputs and the off-core debug port (host FIFO / JTAG bridge).

Parameters:
- SRC_NUM, 4, number of requesting sources (2..8).
- WORD_WIDTH, 32, output beat width in bits.
- REC_WORDS, 4, beats per record (2..16).
- TS_WIDTH, 32, timestamp counter width (used only with the optional feature; must be <= WORD_WIDTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new grants are issued; a record in flight still completes.
- srcReq  in  SRC_NUM  per-source request; the source holds it and srcRecord stable until acked.
- srcRecord  in  SRC_NUM x (REC_WORDS*WORD_WIDTH)  per-source record; word k = bits [k*WORD_WIDTH +: WORD_WIDTH].
- srcAck  out  SRC_NUM  one-hot, one-cycle grant/capture pulse.
- outValid  out  1  beat valid.
- outReady  in  1  sink accepts the beat.
- outData  out  WORD_WIDTH  beat payload.
- outLast  out  1  high on the final beat of a record.
- outSrc  out  max(1,$clog2(SRC_NUM))  index of the source owning the current record.
- busy  out  1  high while in state SEND.

Behaviour:
- Reset (rst low, asynchronous) values:
  - state = IDLE; rrPtr = 0 (source 0 highest priority); beat index idx = 0; snapshot = 0.
  - srcAck = 0, outValid = 0, outLast = 0, outData = 0, outSrc = 0, busy = 0.
- State IDLE:
  - Transition: if enable && |srcReq, grant g = first requesting index scanning rrPtr, rrPtr+1, ... modulo SRC_NUM.
  - srcAck[g] is driven combinationally in this same cycle.
  - At the clock edge: snapshot <= srcRecord[g]; outSrc <= g; rrPtr <= (g+1) mod SRC_NUM; idx <= 0; state <= SEND.
  - Otherwise: stay in IDLE and do not change rrPtr.
- State SEND:
  - outValid = 1, outData = snapshot word idx, outLast = (idx == REC_WORDS-1), busy = 1.
  - When outValid && outReady and not last: idx increments.
  - When outValid && outReady and last: idx <= 0 and state <= IDLE.
  - When outReady is low, outData, outLast and outSrc hold stable. No beat is ever dropped or repeated.
  - srcAck = 0 throughout SEND. Requests arriving during SEND wait.
- Latency and throughput:
  - srcAck cycle to first outValid: exactly 1 cycle.
  - Back-to-back records with outReady held high: REC_WORDS+1 cycles per record (one IDLE cycle between records).
- Boundary conditions:
  - Wrap-around: rrPtr = SRC_NUM-1 with a grant to SRC_NUM-1 gives rrPtr = 0.
  - Starvation bound: a source with a held request is granted within SRC_NUM grants.
  - enable dropping mid-SEND: the current record finishes; no new grant until enable returns high.
  - srcReq deasserted without an ack: the request is withdrawn and no state changes.
  - Reset mid-record: the partial record is discarded. The sink sees outValid fall asynchronously.
- Width rules: idx is $clog2(REC_WORDS) bits wide (minimum 1). All index arithmetic is unsigned modulo.

Optional Feature:
- Macro: RSD_DEBUG_ARB_TIMESTAMP_EN.
- When defined:
  - A free-running TS_WIDTH-bit cycle counter runs from reset value 0 and wraps silently.
  - Its value is captured at the srcAck edge.
  - Each record gains a header beat 0 = {zero-extend, timestamp}, so a record is REC_WORDS+1 beats.
  - The record words follow in order. outLast marks beat REC_WORDS.
  - Back-to-back throughput becomes REC_WORDS+2 cycles.
- When undefined: there is no counter, no header beat, and exactly REC_WORDS beats per record.

Test Plan:
- Reset state: hold rst low, then release with no requests -> srcAck = 0, outValid = 0 and busy = 0 for 10 cycles.
- Single record: srcReq = 4'b0100, srcRecord[2] words = {0xD,0xC,0xB,0xA} (word 0 = 0xA), outReady = 1:
  - srcAck = 4'b0100 in cycle 0.
  - Beats 0xA, 0xB, 0xC, 0xD in cycles 1-4 with outSrc = 2; outLast only in cycle 4.
- Round-robin and wrap: all four requests held continuously -> grant order 0, 1, 2, 3, 0; each srcAck is 5 cycles after the previous one.
- Backpressure: single record with outReady low for 3 cycles on beat 1 -> outData stays 0xB and outValid stays high for those cycles; the sink receives exactly 4 beats, no duplicates.
- Enable gating: enable dropped mid-record, with source 1 also requesting -> the current record completes; no srcAck[1] until enable rises; srcAck[1] in the first cycle it is high.
- Timestamp (macro defined): the first grant occurs at cycle 7 after reset release -> header beat = 0x00000007, then 4 data beats; outLast on beat 4.

Source files
------------

// File: rtl/debug_record_arbiter.sv
// debug_record_arbiter
// Shares one narrow debug output channel among SRC_NUM record sources.
// A round-robin arbiter picks a requester and snapshots its record in the
// ack cycle. The record is then streamed as REC_WORDS beats over
// valid/ready, with outLast on the final beat.
// Optional feature macro: RSD_DEBUG_ARB_TIMESTAMP_EN. When it is defined,
// a free-running cycle counter is captured at grant and sent as a header
// beat ahead of the record words.
module debug_record_arbiter #(
    parameter int SRC_NUM    = 4,
    parameter int WORD_WIDTH = 32,
    parameter int REC_WORDS  = 4,
    parameter int TS_WIDTH   = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          enable,
    input  logic [SRC_NUM-1:0]                            srcReq,
    input  logic [SRC_NUM-1:0][REC_WORDS*WORD_WIDTH-1:0]  srcRecord,
    output logic [SRC_NUM-1:0]                            srcAck,
    output logic                                          outValid,
    input  logic                                          outReady,
    output logic [WORD_WIDTH-1:0]                         outData,
    output logic                                          outLast,
    output logic [((SRC_NUM > 1) ? $clog2(SRC_NUM) : 1)-1:0] outSrc,
    output logic                                          busy
);

    localparam int PW = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
`ifdef RSD_DEBUG_ARB_TIMESTAMP_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int BEATS = REC_WORDS + HDR;
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Reject parameter sets the datapath was not built for.
    if (SRC_NUM < 2 || SRC_NUM > 8 || REC_WORDS < 2 || REC_WORDS > 16 ||
        TS_WIDTH > WORD_WIDTH) begin : g_param_check
        $error("debug_record_arbiter: unsupported parameter set");
    end

    logic [0:0]                            state_q, state_d;
    logic [PW-1:0]                         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]                         idx_q, idx_d;
    logic [BEATS-1:0][WORD_WIDTH-1:0]      snap_q, snap_d;
    logic [PW-1:0]                         src_q, src_d;

    logic [PW-1:0]      cand_idx [SRC_NUM];
    logic [SRC_NUM-1:0] cand_hit;
    logic               grant_valid;
    logic [PW-1:0]      grant_idx;
    logic               grant_fire;
    logic               last_beat;

`ifdef RSD_DEBUG_ARB_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q, ts_d;

    // Free-running cycle counter; wraps silently.
    always_comb begin
        ts_d = ts_q + 1'b1;
    end

    // Timestamp counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_q <= '0;
        else      ts_q <= ts_d;
    end
`endif

    // Candidate gi is the source at offset gi from the round-robin pointer.
    for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_cand
        logic [PW:0] sum;

        // Modulo-SRC_NUM rotation of the priority pointer.
        always_comb begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(gi);
            if (sum >= (PW+1)'(SRC_NUM)) sum = sum - (PW+1)'(SRC_NUM);
        end

        assign cand_idx[gi] = sum[PW-1:0];
        assign cand_hit[gi] = srcReq[sum[PW-1:0]];
    end

    // Pick the requester closest to the pointer; lower offsets overwrite higher.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[i];
            end
        end
    end

    assign grant_fire = (state_q == ST_IDLE) && enable && grant_valid;
    assign last_beat  = (idx_q == IW'(BEATS - 1));

    // One-hot ack pulse in the grant cycle only.
    always_comb begin
        srcAck = '0;
        if (grant_fire) srcAck[grant_idx] = 1'b1;
    end

    // Arbitration / streaming next-state logic.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        src_d    = src_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_fire) begin
`ifdef RSD_DEBUG_ARB_TIMESTAMP_EN
                    snap_d = {srcRecord[grant_idx], WORD_WIDTH'(ts_q)};
`else
                    snap_d = srcRecord[grant_idx];
`endif
                    src_d    = grant_idx;
                    rr_ptr_d = (grant_idx == PW'(SRC_NUM - 1)) ? '0 : grant_idx + 1'b1;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (outReady) begin
                    if (last_beat) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any partial record.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            snap_q   <= '0;
            src_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            src_q    <= src_d;
        end
    end

    assign outValid = (state_q == ST_SEND);
    assign busy     = (state_q == ST_SEND);
    assign outLast  = (state_q == ST_SEND) && last_beat;
    assign outData  = (state_q == ST_SEND) ? snap_q[idx_q] : '0;
    assign outSrc   = src_q;

endmodule

// File: tb/tb_debug_record_arbiter.sv
// Directed testbench for debug_record_arbiter (SRC_NUM=4, 32-bit words, 4 words).
module tb_debug_record_arbiter;

`ifdef RSD_DEBUG_ARB_TIMESTAMP_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int BEATS  = 4 + HDR;
    localparam int PERIOD = BEATS + 1;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [3:0]        srcReq;
    logic [3:0][127:0] srcRecord;
    logic [3:0]        srcAck;
    logic              outValid;
    logic              outReady;
    logic [31:0]       outData;
    logic              outLast;
    logic [1:0]        outSrc;
    logic              busy;

    int total = 0;
    int bad   = 0;

    debug_record_arbiter #(
        .SRC_NUM(4), .WORD_WIDTH(32), .REC_WORDS(4), .TS_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .srcReq(srcReq),
        .srcRecord(srcRecord), .srcAck(srcAck), .outValid(outValid),
        .outReady(outReady), .outData(outData), .outLast(outLast),
        .outSrc(outSrc), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; srcReq = '0; enable = 1'b0; outReady = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; srcReq = '0; outReady = 1'b0; srcRecord = '0;
        repeat (3) @(posedge clk);
        #2;
        total++; if (outValid !== 1'b0 || busy !== 1'b0 || outLast !== 1'b0) begin bad++; $display("FAIL reset_hold: valid=%b busy=%b last=%b want 0 0 0", outValid, busy, outLast); end
        total++; if (outData !== 32'h0 || outSrc !== 2'd0) begin bad++; $display("FAIL reset_data: data=%h src=%0d want 0 0", outData, outSrc); end
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++; if (srcAck !== 4'b0000) begin bad++; $display("FAIL reset_ack c=%0d: got %b want 0000", c, srcAck); end
            total++; if (outValid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_idle c=%0d: valid=%b busy=%b want 0 0", c, outValid, busy); end
            next_cycle();
        end
        $display("test_reset: 10 idle cycles observed");
    endtask

    task automatic test_single();
        enable = 1'b1; outReady = 1'b1;
        srcRecord[2] = {32'hD, 32'hC, 32'hB, 32'hA};
        srcReq = 4'b0100;
        #1;
        total++; if (srcAck !== 4'b0100) begin bad++; $display("FAIL single_ack: got %b want 0100", srcAck); end
        next_cycle();
        srcReq = 4'b0000;
        for (int b = 0; b < BEATS; b++) begin
            #1;
            total++; if (outValid !== 1'b1 || outSrc !== 2'd2 || srcAck !== 4'b0000) begin bad++; $display("FAIL single_beat b=%0d: valid=%b src=%0d ack=%b want 1 2 0000", b, outValid, outSrc, srcAck); end
            total++; if (outLast !== (b == BEATS - 1)) begin bad++; $display("FAIL single_last b=%0d: got %b want %b", b, outLast, (b == BEATS - 1)); end
            if (b >= HDR) begin
                total++; if (outData !== 32'hA + 32'(b - HDR)) begin bad++; $display("FAIL single_data b=%0d: got %h want %h", b, outData, 32'hA + 32'(b - HDR)); end
            end
            next_cycle();
        end
        #1;
        total++; if (outValid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_end: valid=%b busy=%b want 0 0", outValid, busy); end
        $display("test_single: record from source 2 streamed");
    endtask

    task automatic test_round_robin();
        do_reset();
        enable = 1'b1; outReady = 1'b1;
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 4; k++)
                srcRecord[s][k*32 +: 32] = 32'(s * 65536 + k);
        srcReq = 4'b1111;
        for (int c = 0; c <= 4 * PERIOD; c++) begin
            int ph;
            int g;
            logic [3:0] exp_ack;
            ph = c % PERIOD;
            g  = (c / PERIOD) % 4;
            exp_ack = (ph == 0) ? 4'(1 << g) : 4'b0000;
            #1;
            total++; if (srcAck !== exp_ack) begin bad++; $display("FAIL rr_ack c=%0d: got %b want %b", c, srcAck, exp_ack); end
            if (ph >= 1) begin
                total++; if (outValid !== 1'b1 || outSrc !== 2'(g)) begin bad++; $display("FAIL rr_src c=%0d: valid=%b src=%0d want 1 %0d", c, outValid, outSrc, g); end
                if (ph - 1 >= HDR) begin
                    total++; if (outData !== 32'(g * 65536 + (ph - 1 - HDR))) begin bad++; $display("FAIL rr_data c=%0d: got %h want %h", c, outData, 32'(g * 65536 + (ph - 1 - HDR))); end
                end
            end
            if (ph == 0) $display("test_round_robin: grant to source %0d at cycle %0d", g, c);
            next_cycle();
        end
        srcReq = 4'b0000;
        repeat (BEATS) next_cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] got [16];
        int n;
        n = 0;
        outReady = 1'b1;
        srcRecord[2] = {32'hD, 32'hC, 32'hB, 32'hA};
        srcReq = 4'b0100;
        #1;
        total++; if (srcAck !== 4'b0100) begin bad++; $display("FAIL bp_ack: got %b want 0100", srcAck); end
        next_cycle();
        srcReq = 4'b0000;
        for (int c = 1; c <= 12; c++) begin
            outReady = !(c >= 2 + HDR && c <= 4 + HDR);
            #1;
            if (c >= 2 + HDR && c <= 4 + HDR) begin
                total++; if (outValid !== 1'b1 || outData !== 32'hB || outLast !== 1'b0) begin bad++; $display("FAIL bp_hold c=%0d: valid=%b data=%h last=%b want 1 0000000b 0", c, outValid, outData, outLast); end
            end
            if (outValid === 1'b1 && outReady === 1'b1 && n < 16) begin
                got[n] = outData;
                n++;
            end
            next_cycle();
        end
        outReady = 1'b1;
        total++; if (n !== BEATS) begin bad++; $display("FAIL bp_count: got %0d beats want %0d", n, BEATS); end
        for (int k = 0; k < 4; k++) begin
            if (HDR + k < n) begin
                total++; if (got[HDR + k] !== 32'hA + 32'(k)) begin bad++; $display("FAIL bp_seq k=%0d: got %h want %h", k, got[HDR + k], 32'hA + 32'(k)); end
            end
        end
        $display("test_backpressure: %0d beats received", n);
    endtask

    task automatic test_enable_gating();
        outReady = 1'b1; enable = 1'b1;
        srcRecord[0] = {32'h13, 32'h12, 32'h11, 32'h10};
        srcRecord[1] = {32'h23, 32'h22, 32'h21, 32'h20};
        srcReq = 4'b0011;
        #1;
        total++; if (srcAck !== 4'b0001) begin bad++; $display("FAIL en_first_ack: got %b want 0001", srcAck); end
        next_cycle();
        srcReq = 4'b0010; enable = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            #1;
            total++; if (srcAck !== 4'b0000 || outValid !== 1'b1) begin bad++; $display("FAIL en_inflight b=%0d: ack=%b valid=%b want 0000 1", b, srcAck, outValid); end
            if (b >= HDR) begin
                total++; if (outData !== 32'h10 + 32'(b - HDR)) begin bad++; $display("FAIL en_data b=%0d: got %h want %h", b, outData, 32'h10 + 32'(b - HDR)); end
            end
            next_cycle();
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (srcAck !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL en_gated c=%0d: ack=%b busy=%b want 0000 0", c, srcAck, busy); end
            next_cycle();
        end
        enable = 1'b1;
        #1;
        total++; if (srcAck !== 4'b0010) begin bad++; $display("FAIL en_resume_ack: got %b want 0010", srcAck); end
        next_cycle();
        srcReq = 4'b0000;
        repeat (BEATS) next_cycle();
        $display("test_enable_gating: source 1 granted after enable returned");
    endtask

    task automatic test_withdraw_wrap();
        enable = 1'b0; srcReq = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (srcAck !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL wd_disabled c=%0d: ack=%b busy=%b want 0000 0", c, srcAck, busy); end
            next_cycle();
        end
        srcReq = 4'b0000; enable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (srcAck !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL wd_withdrawn c=%0d: ack=%b busy=%b want 0000 0", c, srcAck, busy); end
            next_cycle();
        end
        srcReq = 4'b1001;
        #1;
        total++; if (srcAck !== 4'b1000) begin bad++; $display("FAIL wd_ptr_kept: got %b want 1000", srcAck); end
        next_cycle();
        srcReq = 4'b0001;
        for (int b = 0; b < BEATS; b++) begin
            #1;
            total++; if (outSrc !== 2'd3) begin bad++; $display("FAIL wd_src b=%0d: got %0d want 3", b, outSrc); end
            next_cycle();
        end
        #1;
        total++; if (srcAck !== 4'b0001) begin bad++; $display("FAIL wrap_ack: got %b want 0001", srcAck); end
        next_cycle();
        srcReq = 4'b0000;
        repeat (BEATS) next_cycle();
        $display("test_withdraw_wrap: pointer kept, then wrapped to source 0");
    endtask

    task automatic test_reset_mid();
        srcReq = 4'b0100; enable = 1'b1; outReady = 1'b1;
        #1;
        total++; if (srcAck !== 4'b0100) begin bad++; $display("FAIL rm_ack: got %b want 0100", srcAck); end
        next_cycle();
        srcReq = 4'b0000;
        next_cycle();
        #1;
        total++; if (outValid !== 1'b1) begin bad++; $display("FAIL rm_inflight: valid=%b want 1", outValid); end
        rst = 1'b0;
        #1;
        total++; if (outValid !== 1'b0 || busy !== 1'b0 || outLast !== 1'b0) begin bad++; $display("FAIL rm_async: valid=%b busy=%b last=%b want 0 0 0", outValid, busy, outLast); end
        total++; if (outData !== 32'h0 || outSrc !== 2'd0) begin bad++; $display("FAIL rm_clear: data=%h src=%0d want 0 0", outData, outSrc); end
        next_cycle();
        rst = 1'b1;
        srcReq = 4'b1001;
        #1;
        total++; if (srcAck !== 4'b0001) begin bad++; $display("FAIL rm_ptr_reset: got %b want 0001", srcAck); end
        next_cycle();
        srcReq = 4'b0000;
        repeat (BEATS) next_cycle();
        $display("test_reset_mid: partial record discarded");
    endtask

`ifdef RSD_DEBUG_ARB_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        enable = 1'b1; outReady = 1'b1;
        srcRecord[1] = {32'hD, 32'hC, 32'hB, 32'hA};
        for (int c = 0; c < 7; c++) begin
            #1;
            total++; if (srcAck !== 4'b0000) begin bad++; $display("FAIL ts_idle c=%0d: got %b want 0000", c, srcAck); end
            next_cycle();
        end
        srcReq = 4'b0010;
        #1;
        total++; if (srcAck !== 4'b0010) begin bad++; $display("FAIL ts_ack: got %b want 0010", srcAck); end
        next_cycle();
        srcReq = 4'b0000;
        for (int b = 0; b < 5; b++) begin
            logic [31:0] exp_d;
            exp_d = (b == 0) ? 32'h7 : 32'hA + 32'(b - 1);
            #1;
            total++; if (outData !== exp_d || outLast !== (b == 4)) begin bad++; $display("FAIL ts_beat b=%0d: data=%h last=%b want %h %b", b, outData, outLast, exp_d, (b == 4)); end
            next_cycle();
        end
        $display("test_timestamp: header beat carried grant cycle");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_enable_gating();
        test_withdraw_wrap();
        test_reset_mid();
`ifdef RSD_DEBUG_ARB_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
